// File: rtl/irq_ctrl_m_if.sv
// CPU-side control signals of the interrupt controller register block.
//   reg_address  : register offset (cpu_address[1:0])
//   write_enable : 1 = CPU write, 0 = CPU read
//   SELECT_irq   : block selected by the address decoder
// The 8-bit data bus is a bidirectional net and stays a plain inout port on the controller.
interface irq_ctrl_m_if;
  logic [1:0] reg_address;
  logic       write_enable;
  logic       SELECT_irq;

  modport master (
    output reg_address,
    output write_enable,
    output SELECT_irq
  );

  modport slave (
    input reg_address,
    input write_enable,
    input SELECT_irq
  );
endinterface

// File: rtl/irq_ctrl_m.sv
// Memory-mapped interrupt controller for N_SRC asynchronous sources.
// Each source is synchronised, latched into PENDING as level- or rising-edge-triggered,
// masked, and combined into one registered CPU interrupt line.
// Ports:
//   clk_12_5875 : system clock
//   rst         : asynchronous reset, active-high
//   irq_src     : raw interrupt sources (asynchronous, active-high)
//   bus         : register select / offset / direction (slave modport)
//   data        : bidirectional CPU data bus, driven only on a selected read
//   irq         : registered interrupt request, active-high
// Register map: 0 PENDING (R, W1C), 1 MASK (R/W), 2 VECTOR (R), 3 EDGE (R/W; 1 = rising edge).
module irq_ctrl_m #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  MASK_RESET  = 8'h00,
  parameter logic [7:0]  EDGE_RESET  = 8'h00
) (
  input  logic             clk_12_5875,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  irq_ctrl_m_if.slave      bus,
  inout  wire  [7:0]       data,
  output logic             irq
);

  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrVector  = 2'd2;
  localparam logic [1:0] AddrEdge    = 2'd3;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_mode_q, edge_mode_d;
  logic             irq_q, irq_d;

  logic [N_SRC-1:0] sync;
  logic [N_SRC-1:0] set;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic             wr;
  logic [N_SRC-1:0] wr_data;
  logic [2:0]       idx;
  logic [7:0]       vector;
  logic [7:0]       rd_data;
  logic             rd_oe;
  logic             unused_data;

  // Bits above N_SRC are write-ignored; fold them here so they are not flagged as unused.
  assign unused_data = ^data;

  assign wr      = bus.SELECT_irq & bus.write_enable;
  assign wr_data = data[N_SRC-1:0];
  assign sync    = sync_q[SYNC_STAGES-1];
  assign active  = pending_q & mask_q;

  always_comb begin
    sync_d[0] = irq_src;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    prev_d = sync;
    // Edge-mode sources need a 0->1 transition; level-mode sources set whenever high.
    set    = sync & ~(edge_mode_q & prev_q);
    clr    = (wr && bus.reg_address == AddrPending) ? wr_data : '0;
    // Set has priority over a simultaneous W1C clear.
    pending_d   = set | (pending_q & ~clr);
    mask_d      = (wr && bus.reg_address == AddrMask) ? wr_data : mask_q;
    edge_mode_d = (wr && bus.reg_address == AddrEdge) ? wr_data : edge_mode_q;
    irq_d       = |active;
  end

  // Lowest-numbered active source wins: scan downwards so the last hit is the lowest.
  always_comb begin
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) idx = 3'(i);
    end
    vector = (|active) ? {1'b1, 4'b0000, idx} : 8'h00;
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (bus.reg_address)
      AddrPending: rd_data = 8'(pending_q);
      AddrMask:    rd_data = 8'(mask_q);
      AddrVector:  rd_data = vector;
      AddrEdge:    rd_data = 8'(edge_mode_q);
      default:     rd_data = 8'h00;
    endcase
  end

  assign rd_oe = bus.SELECT_irq & ~bus.write_enable;
  assign data  = rd_oe ? rd_data : 8'bz;
  assign irq   = irq_q;

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_RESET[N_SRC-1:0];
      edge_mode_q <= EDGE_RESET[N_SRC-1:0];
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      edge_mode_q <= edge_mode_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_irq_ctrl_m.sv
module tb_irq_ctrl_m;

  logic       clk_12_5875 = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_src = 4'h0;
  logic       irq;
  wire  [7:0] data;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drive = 1'b0;
  logic [7:0] rv;

  int total = 0;
  int bad   = 0;

  irq_ctrl_m_if bus ();

  assign data = tb_drive ? tb_data : 8'bz;

  irq_ctrl_m dut (
    .clk_12_5875 (clk_12_5875),
    .rst         (rst),
    .irq_src     (irq_src),
    .bus         (bus),
    .data        (data),
    .irq         (irq)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_12_5875);
    #1;
  endtask

  // Write commits on the second rising edge after the call; returns 1ns after it.
  task automatic reg_wr(input logic [1:0] addr, input logic [7:0] val);
    @(posedge clk_12_5875);
    #1;
    bus.SELECT_irq   = 1'b1;
    bus.write_enable = 1'b1;
    bus.reg_address  = addr;
    tb_data          = val;
    tb_drive         = 1'b1;
    @(posedge clk_12_5875);
    #1;
    bus.SELECT_irq   = 1'b0;
    bus.write_enable = 1'b0;
    tb_drive         = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] addr, output logic [7:0] val);
    bus.SELECT_irq   = 1'b1;
    bus.write_enable = 1'b0;
    bus.reg_address  = addr;
    #1;
    val = data;
    bus.SELECT_irq = 1'b0;
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] v;
    reg_rd(addr, v);
    check_eq(tag, v, exp);
  endtask

  initial begin
    bus.SELECT_irq   = 1'b0;
    bus.write_enable = 1'b0;
    bus.reg_address  = 2'd0;
    #12;
    rst = 1'b0;
    tick(1);

    // Reset state
    check_eq("rst_irq", {7'b0, irq}, 8'h00);
    rd_check("rst_pending", 2'd0, 8'h00);
    rd_check("rst_mask", 2'd1, 8'h00);
    rd_check("rst_vector", 2'd2, 8'h00);
    rd_check("rst_edge", 2'd3, 8'h00);

    // Edge latency on source 0
    reg_wr(2'd3, 8'h01);
    reg_wr(2'd1, 8'h01);
    irq_src[0] = 1'b1;
    tick(2);
    rd_check("edge_pend_e2", 2'd0, 8'h00);
    tick(1);
    rd_check("edge_pend_e3", 2'd0, 8'h01);
    check_eq("edge_irq_e3", {7'b0, irq}, 8'h00);
    tick(1);
    check_eq("edge_irq_e4", {7'b0, irq}, 8'h01);
    reg_wr(2'd0, 8'h01);
    rd_check("edge_w1c_pend", 2'd0, 8'h00);
    tick(1);
    check_eq("edge_w1c_irq", {7'b0, irq}, 8'h00);
    tick(3);
    rd_check("edge_no_reset", 2'd0, 8'h00);
    irq_src[0] = 1'b0;
    tick(3);

    // Level re-arm on source 1
    reg_wr(2'd3, 8'h00);
    reg_wr(2'd1, 8'h02);
    irq_src[1] = 1'b1;
    tick(4);
    rd_check("lvl_pend", 2'd0, 8'h02);
    reg_wr(2'd0, 8'h02);
    rd_check("lvl_rearm", 2'd0, 8'h02);
    irq_src[1] = 1'b0;
    tick(3);
    reg_wr(2'd0, 8'h02);
    rd_check("lvl_cleared", 2'd0, 8'h00);
    tick(2);
    rd_check("lvl_stays0", 2'd0, 8'h00);

    // Priority and mask
    irq_src = 4'b1010;
    tick(4);
    irq_src = 4'b0000;
    tick(4);
    rd_check("prio_pend", 2'd0, 8'h0A);
    reg_wr(2'd1, 8'h0A);
    rd_check("prio_vec_0a", 2'd2, 8'h81);
    tick(1);
    check_eq("prio_irq_on", {7'b0, irq}, 8'h01);
    reg_wr(2'd1, 8'h08);
    rd_check("prio_vec_08", 2'd2, 8'h83);
    reg_wr(2'd1, 8'h00);
    rd_check("prio_vec_00", 2'd2, 8'h00);
    tick(1);
    check_eq("prio_irq_off", {7'b0, irq}, 8'h00);
    rd_check("prio_pend_kept", 2'd0, 8'h0A);
    reg_wr(2'd1, 8'h0A);
    tick(1);
    check_eq("unmask_irq", {7'b0, irq}, 8'h01);
    reg_wr(2'd1, 8'h00);
    reg_wr(2'd0, 8'hFF);
    rd_check("prio_clear", 2'd0, 8'h00);

    // Set/clear collision on source 2
    reg_wr(2'd3, 8'h04);
    irq_src[2] = 1'b1;
    tick(4);
    rd_check("coll_pre", 2'd0, 8'h04);
    irq_src[2] = 1'b0;
    tick(3);
    irq_src[2] = 1'b1;
    tick(1);
    reg_wr(2'd0, 8'h04);   // commits on the edge where set_2 fires
    rd_check("coll_setwins", 2'd0, 8'h04);
    reg_wr(2'd0, 8'h04);
    rd_check("coll_clear", 2'd0, 8'h00);

    // Bounds and read-only offset
    reg_wr(2'd1, 8'hFF);
    rd_check("bnd_mask", 2'd1, 8'h0F);
    reg_wr(2'd2, 8'hFF);
    rd_check("bnd_ro_mask", 2'd1, 8'h0F);
    rd_check("bnd_ro_edge", 2'd3, 8'h04);
    rd_check("bnd_ro_pend", 2'd0, 8'h00);
    reg_wr(2'd3, 8'hF5);
    rd_check("bnd_edge", 2'd3, 8'h05);

    // Asynchronous reset mid-cycle; source 2 is high and level-mode makes irq assert
    reg_wr(2'd3, 8'h00);
    tick(3);
    check_eq("pre_rst_irq", {7'b0, irq}, 8'h01);
    #3;
    rst = 1'b1;
    irq_src = 4'h0;
    #1;
    check_eq("async_rst_irq", {7'b0, irq}, 8'h00);
    #2;
    rst = 1'b0;
    tick(1);
    rd_check("rst2_mask", 2'd1, 8'h00);
    rd_check("rst2_pend", 2'd0, 8'h00);
    rd_check("rst2_edge", 2'd3, 8'h00);

    // Unselected read must leave the bus to other drivers
    tb_data  = 8'hA5;
    tb_drive = 1'b1;
    bus.SELECT_irq   = 1'b0;
    bus.write_enable = 1'b0;
    #1;
    check_eq("bus_released", data, 8'hA5);
    tb_drive = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
